// File: rtl/fios_scheduler_if.sv
// Request/strobe bundle between an FIOS Montgomery datapath controller and its scheduler.
// Signal names keep the scheduler's port directions as suffixes.
interface fios_scheduler_if #(
  parameter int unsigned S     = 8,
  parameter int unsigned PE_NB = 8,
  parameter int unsigned ID_W  = 2
);
  localparam int unsigned IW = $clog2(S);

  logic              req_valid_i;
  logic              req_ready_o;
  logic [ID_W-1:0]   req_id_i;
  logic              abort_i;
  logic              b_fetch_o;
  logic              p_fetch_o;
  logic [IW-1:0]     word_idx_o;
  logic [PE_NB-1:0]  pe_start_o;
  logic              a_shift_o;
  logic              res_push_o;
  logic [IW-1:0]     res_idx_o;
  logic [ID_W-1:0]   res_id_o;
  logic              done_o;
  logic              aborted_o;
  logic              busy_o;

  modport slave (
    input  req_valid_i, req_id_i, abort_i,
    output req_ready_o, b_fetch_o, p_fetch_o, word_idx_o, pe_start_o, a_shift_o,
           res_push_o, res_idx_o, res_id_o, done_o, aborted_o, busy_o
  );

  modport master (
    output req_valid_i, req_id_i, abort_i,
    input  req_ready_o, b_fetch_o, p_fetch_o, word_idx_o, pe_start_o, a_shift_o,
           res_push_o, res_idx_o, res_id_o, done_o, aborted_o, busy_o
  );
endinterface

// File: rtl/fios_scheduler.sv
// Cycle scheduler for an FIOS Montgomery multiplier: sequences operand fetches, PE starts,
// a-register shifts and result pushes over one or more folded passes.
module fios_scheduler #(
  parameter int unsigned S          = 8,
  parameter int unsigned PE_NB      = 8,
  parameter int unsigned PE_DELAY   = 6,
  parameter int unsigned LOOP_DELAY = 0,
  parameter int unsigned RES_OFFSET = 3,
  parameter int unsigned ID_W       = 2
) (
  input logic           clock_i,
  input logic           reset_n_i,
  fios_scheduler_if.slave bus
);

  localparam int unsigned IW        = $clog2(S);
  localparam int unsigned P         = (S + PE_NB - 1) / PE_NB;
  localparam int unsigned T_LOOP    = PE_NB * PE_DELAY + LOOP_DELAY;
  localparam int unsigned T_PASS    = (S + 2 > T_LOOP) ? S + 2 : T_LOOP;
  localparam int unsigned T_R       = (P - 1) * T_PASS + ((S - 1) % PE_NB) * PE_DELAY
                                      + RES_OFFSET;
  localparam int unsigned T_END     = T_R + S;
  localparam int unsigned T_RUN     = P * T_PASS;
  // Results overrunning the last pass keep RUN for the full pass; otherwise DRAIN at t_R.
  localparam int unsigned T_DRAIN   = (T_END > T_RUN) ? T_RUN : T_R;
  localparam int unsigned A_SHIFT_C = (PE_NB - 1) * PE_DELAY + 1;
  localparam int unsigned TW        = $clog2(T_END + 1);
  localparam int unsigned CW        = $clog2(T_PASS);
  localparam int unsigned PW        = $clog2(P + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [CW-1:0]     c_q, c_d;
  logic [PW-1:0]     p_q, p_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic              ready_q, ready_d;
  logic              fetch_q, fetch_d;
  logic [IW-1:0]     widx_q, widx_d;
  logic [PE_NB-1:0]  pe_start_q, pe_start_d;
  logic              a_shift_q, a_shift_d;
  logic              push_q, push_d;
  logic [IW-1:0]     ridx_q, ridx_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              busy_q, busy_d;

  // Next-state: t counts cycles since acceptance, c/p track position within the pass.
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    c_d       = c_q;
    p_d       = p_q;
    id_d      = id_q;
    aborted_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        t_d = '0;
        c_d = '0;
        p_d = '0;
        if (bus.req_valid_i && ready_q) begin
          state_d = StRun;
          id_d    = bus.req_id_i;
        end
      end
      StRun, StDrain: begin
        t_d = t_q + 1'b1;
        if (c_q == CW'(T_PASS - 1)) begin
          c_d = '0;
          if (p_q != PW'(P)) p_d = p_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
        if (state_q == StRun) begin
          if (t_q == TW'(T_DRAIN - 1)) state_d = StDrain;
        end else if (t_q == TW'(T_END - 1)) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
    endcase
    if (bus.abort_i && state_q != StIdle) begin
      state_d   = StIdle;
      t_d       = '0;
      c_d       = '0;
      p_d       = '0;
      aborted_d = 1'b1;
    end
  end

  // Output decode of the next state, registered below.
  logic        active, in_pass;
  int unsigned c_ext, p_ext;

  always_comb begin
    active     = (state_d == StRun) || (state_d == StDrain);
    in_pass    = active && (p_d < PW'(P));
    c_ext      = 32'(c_d);
    p_ext      = 32'(p_d);
    ready_d    = (state_d == StIdle);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
    fetch_d    = in_pass && (c_d < CW'(S));
    widx_d     = fetch_d ? IW'(c_d) : '0;
    pe_start_d = '0;
    for (int unsigned k = 0; k < PE_NB; k++) begin
      pe_start_d[k] = in_pass && (c_ext == k * PE_DELAY) && (p_ext * PE_NB + k < S);
    end
    a_shift_d  = active && (p_ext + 1 < P) && (c_ext == A_SHIFT_C);
    push_d     = active && (t_d >= TW'(T_R)) && (t_d < TW'(T_END));
    ridx_d     = push_d ? IW'(t_d - TW'(T_R)) : '0;
    rid_d      = busy_d ? id_d : '0;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q    <= StIdle;
      t_q        <= '0;
      c_q        <= '0;
      p_q        <= '0;
      id_q       <= '0;
      ready_q    <= 1'b0;
      fetch_q    <= 1'b0;
      widx_q     <= '0;
      pe_start_q <= '0;
      a_shift_q  <= 1'b0;
      push_q     <= 1'b0;
      ridx_q     <= '0;
      rid_q      <= '0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      c_q        <= c_d;
      p_q        <= p_d;
      id_q       <= id_d;
      ready_q    <= ready_d;
      fetch_q    <= fetch_d;
      widx_q     <= widx_d;
      pe_start_q <= pe_start_d;
      a_shift_q  <= a_shift_d;
      push_q     <= push_d;
      ridx_q     <= ridx_d;
      rid_q      <= rid_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.b_fetch_o   = fetch_q;
  assign bus.p_fetch_o   = fetch_q;
  assign bus.word_idx_o  = widx_q;
  assign bus.pe_start_o  = pe_start_q;
  assign bus.a_shift_o   = a_shift_q;
  assign bus.res_push_o  = push_q;
  assign bus.res_idx_o   = ridx_q;
  assign bus.res_id_o    = rid_q;
  // An abort arriving in the DONE cycle still wins over the completion pulse.
  assign bus.done_o      = done_q & ~bus.abort_i;
  assign bus.aborted_o   = aborted_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_fios_scheduler.sv
// Bench: unfolded and folded schedulers driven in lockstep and compared every cycle
// against a schedule model computed from pass arithmetic.
module tb_fios_scheduler;

  localparam int unsigned S    = 8;
  localparam int unsigned ID_W = 2;
  localparam int unsigned D    = 6;
  localparam int unsigned RO   = 3;

  typedef struct packed {
    logic       ready;
    logic       bf;
    logic       pf;
    logic [2:0] widx;
    logic [7:0] pe;
    logic       ash;
    logic       push;
    logic [2:0] ridx;
    logic [1:0] rid;
    logic       done;
    logic       abt;
    logic       busy;
  } obs_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic [ID_W-1:0] req_id = '0;
  logic            abort = 1'b0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  fios_scheduler_if #(.S(S), .PE_NB(8), .ID_W(ID_W)) bus_u ();
  fios_scheduler_if #(.S(S), .PE_NB(3), .ID_W(ID_W)) bus_f ();

  assign bus_u.req_valid_i = req_valid;
  assign bus_u.req_id_i    = req_id;
  assign bus_u.abort_i     = abort;
  assign bus_f.req_valid_i = req_valid;
  assign bus_f.req_id_i    = req_id;
  assign bus_f.abort_i     = abort;

  fios_scheduler #(
    .S(S), .PE_NB(8), .PE_DELAY(6), .LOOP_DELAY(0), .RES_OFFSET(3), .ID_W(ID_W)
  ) u_unf (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (bus_u)
  );

  fios_scheduler #(
    .S(S), .PE_NB(3), .PE_DELAY(6), .LOOP_DELAY(2), .RES_OFFSET(3), .ID_W(ID_W)
  ) u_fold (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (bus_f)
  );

  // Reference model state, index 0 = unfolded, 1 = folded.
  int unsigned     nbs[2] = '{8, 3};
  int unsigned     lds[2] = '{0, 2};
  bit              mbusy[2];
  int unsigned     mt[2];
  logic [ID_W-1:0] mtag[2];
  bit              mrdy[2];
  bit              mabt[2];

  function automatic int unsigned t_pass(int unsigned nb, int unsigned ld);
    int unsigned loop_t = nb * D + ld;
    return (S + 2 > loop_t) ? S + 2 : loop_t;
  endfunction

  function automatic int unsigned t_res(int unsigned nb, int unsigned ld);
    int unsigned np = (S + nb - 1) / nb;
    return (np - 1) * t_pass(nb, ld) + ((S - 1) % nb) * D + RO;
  endfunction

  function automatic obs_t expect_obs(int m, bit abort_now);
    obs_t        o;
    int unsigned nb = nbs[m];
    int unsigned np = (S + nb - 1) / nb;
    int unsigned tp = t_pass(nb, lds[m]);
    int unsigned tr = t_res(nb, lds[m]);
    int unsigned t  = mt[m];
    int unsigned p  = t / tp;
    int unsigned c  = t % tp;
    o       = '0;
    o.ready = !mbusy[m] && mrdy[m];
    o.abt   = mabt[m];
    if (mbusy[m]) begin
      o.busy = 1'b1;
      o.rid  = mtag[m];
      if (t == tr + S) begin
        o.done = !abort_now;
      end else begin
        if (p < np && c < S) begin
          o.bf   = 1'b1;
          o.pf   = 1'b1;
          o.widx = 3'(c);
        end
        for (int unsigned k = 0; k < nb; k++) begin
          if (p < np && c == k * D && p * nb + k < S) o.pe[k] = 1'b1;
        end
        if (p + 1 < np && c == (nb - 1) * D + 1) o.ash = 1'b1;
        if (t >= tr && t < tr + S) begin
          o.push = 1'b1;
          o.ridx = 3'(t - tr);
        end
      end
    end
    return o;
  endfunction

  function automatic obs_t observe(int m);
    obs_t o;
    if (m == 0) begin
      o = {bus_u.req_ready_o, bus_u.b_fetch_o, bus_u.p_fetch_o, bus_u.word_idx_o,
           bus_u.pe_start_o, bus_u.a_shift_o, bus_u.res_push_o, bus_u.res_idx_o,
           bus_u.res_id_o, bus_u.done_o, bus_u.aborted_o, bus_u.busy_o};
    end else begin
      o = {bus_f.req_ready_o, bus_f.b_fetch_o, bus_f.p_fetch_o, bus_f.word_idx_o,
           5'b0, bus_f.pe_start_o, bus_f.a_shift_o, bus_f.res_push_o, bus_f.res_idx_o,
           bus_f.res_id_o, bus_f.done_o, bus_f.aborted_o, bus_f.busy_o};
    end
    return o;
  endfunction

  task automatic update_models(bit v, logic [ID_W-1:0] id, bit ab, bit rn);
    for (int m = 0; m < 2; m++) begin
      int unsigned tend = t_res(nbs[m], lds[m]) + S;
      if (!rn) begin
        mbusy[m] = 1'b0; mt[m] = 0; mtag[m] = '0; mrdy[m] = 1'b0; mabt[m] = 1'b0;
      end else if (mbusy[m] && ab) begin
        mbusy[m] = 1'b0; mabt[m] = 1'b1; mrdy[m] = 1'b1;
      end else if (mbusy[m]) begin
        mabt[m] = 1'b0;
        if (mt[m] == tend) begin
          mbusy[m] = 1'b0;
          mrdy[m]  = 1'b1;
        end else begin
          mt[m] = mt[m] + 1;
        end
      end else begin
        mabt[m] = 1'b0;
        if (mrdy[m] && v) begin
          mbusy[m] = 1'b1;
          mt[m]    = 0;
          mtag[m]  = id;
        end
        mrdy[m] = 1'b1;
      end
    end
  endtask

  task automatic check_all(bit ab);
    for (int m = 0; m < 2; m++) begin
      obs_t e = expect_obs(m, ab);
      obs_t o = observe(m);
      vectors++;
      assert (o === e) else begin
        miscompares++;
        $error("FAIL %s t=%0d busy=%0d observed=%h expected=%h",
               (m == 0) ? "unfolded" : "folded", mt[m], mbusy[m], o, e);
      end
    end
  endtask

  // Drive one cycle of inputs, check mid-cycle, then advance the model across the edge.
  task automatic cycle(bit v, logic [ID_W-1:0] id, bit ab, bit rn);
    req_valid = v;
    req_id    = id;
    abort     = ab;
    rst_n     = rn;
    #1;
    check_all(ab);
    @(posedge clk);
    #1;
    update_models(v, id, ab, rn);
  endtask

  initial begin
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    update_models(1'b0, '0, 1'b0, 1'b0);

    // Reset state, then a request while the release edge has not yet made ready visible.
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 2'd1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Single request, tag 2, run to completion in both configurations.
    cycle(1'b1, 2'd2, 1'b0, 1'b1);
    repeat (62) cycle(1'b0, '0, 1'b0, 1'b1);

    // Back-to-back: valid held high with a changing tag.
    repeat (140) cycle(1'b1, ID_W'($urandom), 1'b0, 1'b1);
    repeat (70) cycle(1'b0, '0, 1'b0, 1'b1);

    // Abort at t=30.
    cycle(1'b1, 2'd1, 1'b0, 1'b1);
    repeat (30) cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b0, 1'b1);

    // Reset at t=20, then a fresh request completes.
    cycle(1'b1, 2'd2, 1'b0, 1'b1);
    repeat (20) cycle(1'b0, '0, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 2'd3, 1'b0, 1'b1);
    repeat (62) cycle(1'b0, '0, 1'b0, 1'b1);

    // Abort landing on the folded DONE cycle (t=57) suppresses done.
    cycle(1'b1, 2'd1, 1'b0, 1'b1);
    repeat (57) cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b0, 1'b1);

    // Random traffic with sporadic aborts and resets.
    repeat (2000) begin
      cycle(($urandom % 4) == 0, ID_W'($urandom), ($urandom % 100) == 0,
            ($urandom % 400) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
